sig_edge_detect_module: RTL and testbench

SIG_EDGE_DETECT_MODULE -- requirements
Module: sig_edge_detect_module

---
 rtl/sig_edge_pkg.sv | 16 +
 rtl/sig_edge_chan.sv | 72 +++++++
 rtl/sig_edge_detect_module.sv | 41 ++++
 tb/tb_sig_edge_detect_module.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/sig_edge_pkg.sv
// sig_edge_pkg: shared edge-mode encodings and the edge qualification rule.
package sig_edge_pkg;

    typedef enum logic [1:0] {
        MODE_NONE = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } mode_e;

    function automatic logic edge_qualifies(input logic [1:0] mode, input logic rise, input logic fall);
        return (rise && (mode == MODE_RISE || mode == MODE_BOTH)) ||
               (fall && (mode == MODE_FALL || mode == MODE_BOTH));
    endfunction

endpackage

// File: rtl/sig_edge_chan.sv
// sig_edge_chan: one channel of synchronizer, glitch filter, edge pulses and saturating edge counter.
module sig_edge_chan
    import sig_edge_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pin_i,
    input  logic [1:0]       mode_i,
    input  logic             cnt_clr_i,
    output logic             level_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             pulse_o,
    output logic [CNT_W-1:0] cnt_o
);
    localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FW-1:0]          filt_q, filt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   pulse_q, pulse_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   s_last, diff, accept;

    // A new level is accepted only on the FILT_LEN-th consecutive differing edge.
    always_comb begin
        s_last  = sync_q[SYNC_STAGES-1];
        diff    = s_last != level_q;
        accept  = diff && (filt_q == FILT_MAX);
        filt_d  = (!diff || accept) ? '0 : filt_q + 1'b1;
        level_d = accept ? s_last : level_q;
        rise_d  = accept && s_last;
        fall_d  = accept && !s_last;
        pulse_d = edge_qualifies(mode_i, rise_d, fall_d);
        cnt_d   = cnt_clr_i ? CNT_W'(pulse_d) :
                  (pulse_d && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            filt_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], pin_i};
            filt_q  <= filt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign pulse_o = pulse_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/sig_edge_detect_module.sv
// sig_edge_detect_module: N_CH independent edge detectors with shared mode select and counter clear.
module sig_edge_detect_module
    import sig_edge_pkg::*;
#(
    parameter int N_CH        = 1,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 1,
    parameter int CNT_W       = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [N_CH-1:0]       Pin_Sig,
    input  logic [1:0]            Mode,
    input  logic                  Cnt_Clr,
    output logic [N_CH-1:0]       Level,
    output logic [N_CH-1:0]       Rise_Sig,
    output logic [N_CH-1:0]       Fall_Sig,
    output logic [N_CH-1:0]       Edge_Pulse,
    output logic [N_CH*CNT_W-1:0] Edge_Cnt
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        sig_edge_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .FILT_LEN   (FILT_LEN),
            .CNT_W      (CNT_W)
        ) u_chan (
            .clk_i    (CLK),
            .rst_i    (RST),
            .pin_i    (Pin_Sig[i]),
            .mode_i   (Mode),
            .cnt_clr_i(Cnt_Clr),
            .level_o  (Level[i]),
            .rise_o   (Rise_Sig[i]),
            .fall_o   (Fall_Sig[i]),
            .pulse_o  (Edge_Pulse[i]),
            .cnt_o    (Edge_Cnt[i*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_sig_edge_detect_module.sv
// tb_sig_edge_detect_module: directed scenarios for the two-channel, 3-cycle-filter configuration.
module tb_sig_edge_detect_module;
    localparam int N_CH = 2;
    localparam int CNT_W = 4;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic [N_CH-1:0]  Pin_Sig = '0;
    logic [1:0]       Mode = 2'b00;
    logic             Cnt_Clr = 1'b0;
    logic [N_CH-1:0]  Level, Rise_Sig, Fall_Sig, Edge_Pulse;
    logic [N_CH*CNT_W-1:0] Edge_Cnt;
    int checks = 0;
    int errors = 0;

    sig_edge_detect_module #(.N_CH(N_CH), .SYNC_STAGES(2), .FILT_LEN(3), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .Pin_Sig(Pin_Sig), .Mode(Mode), .Cnt_Clr(Cnt_Clr),
        .Level(Level), .Rise_Sig(Rise_Sig), .Fall_Sig(Fall_Sig),
        .Edge_Pulse(Edge_Pulse), .Edge_Cnt(Edge_Cnt)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive a new pin pattern for 6 edges; pulses are expected only after the 5th.
    task automatic apply(input logic [N_CH-1:0] v, input int clr_at,
                         output logic [N_CH-1:0] r, output logic [N_CH-1:0] f,
                         output logic [N_CH-1:0] p, output logic extra);
        Pin_Sig = v;
        extra = 1'b0;
        r = '0; f = '0; p = '0;
        for (int e = 1; e <= 6; e++) begin
            Cnt_Clr = (e == clr_at);
            tick();
            if (e == 5) begin
                r = Rise_Sig; f = Fall_Sig; p = Edge_Pulse;
            end else if (|{Rise_Sig, Fall_Sig, Edge_Pulse}) extra = 1'b1;
        end
        Cnt_Clr = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        checks++;
        if ({Level, Rise_Sig, Fall_Sig, Edge_Pulse, Edge_Cnt} !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h expected 0", {Level, Rise_Sig, Fall_Sig, Edge_Pulse, Edge_Cnt});
        end
        RST = 1'b0;
    endtask

    task automatic test_latency();
        Mode = 2'b01;
        Pin_Sig = 2'b01;
        for (int e = 1; e <= 6; e++) begin
            tick();
            checks += 3;
            if (Rise_Sig[0] !== (e == 5)) begin errors++; $display("FAIL latency_rise edge %0d: got %b expected %b", e, Rise_Sig[0], e == 5); end
            if (Edge_Pulse[0] !== (e == 5)) begin errors++; $display("FAIL latency_pulse edge %0d: got %b expected %b", e, Edge_Pulse[0], e == 5); end
            if (Level[0] !== (e >= 5)) begin errors++; $display("FAIL latency_level edge %0d: got %b expected %b", e, Level[0], e >= 5); end
        end
        checks++;
        if (Edge_Cnt[3:0] !== 4'd1) begin errors++; $display("FAIL latency_cnt: got %0d expected 1", Edge_Cnt[3:0]); end
    endtask

    task automatic test_glitch();
        Pin_Sig = 2'b11;
        tick(); tick();
        Pin_Sig = 2'b01;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks += 2;
            if (Level[1] !== 1'b0) begin errors++; $display("FAIL glitch_level edge %0d: got %b expected 0", e, Level[1]); end
            if ({Rise_Sig, Fall_Sig, Edge_Pulse} !== '0) begin errors++; $display("FAIL glitch_pulse edge %0d: got %b expected 0", e, {Rise_Sig, Fall_Sig, Edge_Pulse}); end
        end
    endtask

    task automatic test_mode_fall();
        logic [N_CH-1:0] r, f, p;
        logic x;
        Mode = 2'b00;
        apply(2'b00, 0, r, f, p, x);
        checks += 3;
        if (f !== 2'b01 || r !== 2'b00) begin errors++; $display("FAIL mode_none_fall: got r=%b f=%b expected r=00 f=01", r, f); end
        if (p !== 2'b00) begin errors++; $display("FAIL mode_none_pulse: got %b expected 00", p); end
        if (x !== 1'b0) begin errors++; $display("FAIL mode_none_extra: got %b expected 0", x); end
        Mode = 2'b10;
        apply(2'b01, 0, r, f, p, x);
        checks += 2;
        if (r !== 2'b01) begin errors++; $display("FAIL mode_fall_rise: got %b expected 01", r); end
        if (p !== 2'b00 || x !== 1'b0) begin errors++; $display("FAIL mode_fall_rise_pulse: got p=%b x=%b expected 00/0", p, x); end
        apply(2'b00, 0, r, f, p, x);
        checks += 3;
        if (f !== 2'b01) begin errors++; $display("FAIL mode_fall_fall: got %b expected 01", f); end
        if (p !== 2'b01 || x !== 1'b0) begin errors++; $display("FAIL mode_fall_pulse: got p=%b x=%b expected 01/0", p, x); end
        if (Edge_Cnt[3:0] !== 4'd2) begin errors++; $display("FAIL mode_fall_cnt: got %0d expected 2", Edge_Cnt[3:0]); end
    endtask

    task automatic test_clr_same_edge();
        logic [N_CH-1:0] r, f, p;
        logic x;
        Mode = 2'b11;
        for (int i = 0; i < 5; i++) apply((i % 2 == 0) ? 2'b01 : 2'b00, 0, r, f, p, x);
        checks++;
        if (Edge_Cnt[3:0] !== 4'd7) begin errors++; $display("FAIL clr_precount: got %0d expected 7", Edge_Cnt[3:0]); end
        apply(2'b00, 5, r, f, p, x);
        checks += 2;
        if (p !== 2'b01) begin errors++; $display("FAIL clr_edge_pulse: got %b expected 01", p); end
        if (Edge_Cnt[3:0] !== 4'd1) begin errors++; $display("FAIL clr_same_edge: got %0d expected 1", Edge_Cnt[3:0]); end
        Cnt_Clr = 1'b1;
        tick();
        Cnt_Clr = 1'b0;
        checks++;
        if (Edge_Cnt !== '0) begin errors++; $display("FAIL clr_plain: got %h expected 0", Edge_Cnt); end
    endtask

    task automatic test_saturate();
        logic [N_CH-1:0] r, f, p;
        logic x;
        Mode = 2'b11;
        for (int i = 1; i <= 20; i++) begin
            apply((i % 2 == 1) ? 2'b01 : 2'b00, 0, r, f, p, x);
            checks++;
            if (Edge_Cnt[3:0] !== 4'((i > 15) ? 15 : i)) begin
                errors++; $display("FAIL saturate step %0d: got %0d expected %0d", i, Edge_Cnt[3:0], (i > 15) ? 15 : i);
            end
        end
        checks++;
        if (Edge_Cnt[7:4] !== 4'd0) begin errors++; $display("FAIL saturate_ch1: got %0d expected 0", Edge_Cnt[7:4]); end
    endtask

    task automatic test_simultaneous();
        logic [N_CH-1:0] r, f, p;
        logic x;
        apply(2'b11, 0, r, f, p, x);
        checks += 3;
        if (r !== 2'b11 || p !== 2'b11) begin errors++; $display("FAIL simul_pulses: got r=%b p=%b expected 11/11", r, p); end
        if (x !== 1'b0) begin errors++; $display("FAIL simul_extra: got %b expected 0", x); end
        if (Edge_Cnt !== 8'h1F) begin errors++; $display("FAIL simul_cnt: got %h expected 1f", Edge_Cnt); end
    endtask

    task automatic test_reset_mid_pulse();
        logic [N_CH-1:0] r, f, p;
        logic x;
        apply(2'b00, 0, r, f, p, x);
        Pin_Sig = 2'b01;
        for (int e = 1; e <= 5; e++) tick();
        checks++;
        if (Rise_Sig[0] !== 1'b1) begin errors++; $display("FAIL mid_pulse_pre: got %b expected 1", Rise_Sig[0]); end
        RST = 1'b1;
        #1;
        checks++;
        if ({Level, Rise_Sig, Fall_Sig, Edge_Pulse, Edge_Cnt} !== '0) begin
            errors++; $display("FAIL mid_pulse_reset: got %h expected 0", {Level, Rise_Sig, Fall_Sig, Edge_Pulse, Edge_Cnt});
        end
        tick(); tick();
        RST = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            tick();
            checks += 2;
            if (Rise_Sig[0] !== (e == 5)) begin errors++; $display("FAIL post_reset_rise edge %0d: got %b expected %b", e, Rise_Sig[0], e == 5); end
            if (Level[0] !== (e >= 5)) begin errors++; $display("FAIL post_reset_level edge %0d: got %b expected %b", e, Level[0], e >= 5); end
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_glitch();
        test_mode_fall();
        test_clr_same_edge();
        test_saturate();
        test_simultaneous();
        test_reset_mid_pulse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
